// File: rtl/clarke_pkg.sv
// Shared types and elaboration-time coefficient helpers for the Clarke pipeline.
// Coefficients are exact integer roundings, so no real arithmetic reaches synthesis.
package clarke_pkg;

  typedef enum logic {CLK_2PH, CLK_3PH} clarke_mode_t;

  // Widest channel tag the stage payload can carry.
  localparam int CH_W_MAX = 8;

  typedef struct packed {
    clarke_mode_t        mode;
    logic [CH_W_MAX-1:0] ch;
    logic                valid;
  } stage_t;

  function automatic longint isqrt(input longint n);
    longint r;
    longint c;
    r = 0;
    for (int b = 30; b >= 0; b--) begin
      c = r | (longint'(1) << b);
      if (c * c <= n) r = c;
    end
    return r;
  endfunction

  // round(v) = (floor(2v) + 1) >> 1, with floor(2*2^q/sqrt3) = isqrt(floor(4^(q+1)/3)).
  function automatic int clarke_coef(input int q, input bit inv_sqrt3);
    longint twice;
    if (inv_sqrt3) twice = isqrt((longint'(1) << (2 * q + 2)) / 3);
    else           twice = (longint'(1) << (q + 1)) / 3;
    return int'((twice + 1) >>> 1);
  endfunction

endpackage

// File: rtl/clarke_pipe_if.sv
// Sample-in / result-out handshake bundle for clarke_pipe, plus the saturation counter.
// master drives samples and out_ready; slave is the transform block.
interface clarke_pipe_if #(
  parameter int D_WIDTH   = 32,
  parameter int CH_W      = 2,
  parameter int SAT_CNT_W = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_mode;
  logic [CH_W-1:0]           in_ch;
  logic signed [D_WIDTH-1:0] in_a;
  logic signed [D_WIDTH-1:0] in_b;
  logic signed [D_WIDTH-1:0] in_c;
  logic                      out_valid;
  logic                      out_ready;
  logic [CH_W-1:0]           out_ch;
  logic signed [D_WIDTH-1:0] out_alpha;
  logic signed [D_WIDTH-1:0] out_beta;
  logic                      out_sat;
  logic [SAT_CNT_W-1:0]      sat_cnt;
  logic                      clr_sat;

  modport master (
    output in_valid, in_mode, in_ch, in_a, in_b, in_c, out_ready, clr_sat,
    input  in_ready, out_valid, out_ch, out_alpha, out_beta, out_sat, sat_cnt
  );

  modport slave (
    input  in_valid, in_mode, in_ch, in_a, in_b, in_c, out_ready, clr_sat,
    output in_ready, out_valid, out_ch, out_alpha, out_beta, out_sat, sat_cnt
  );
endinterface

// File: rtl/clarke_rndsat.sv
// Round-half-up, arithmetic shift by SHIFT and clip to OUT_W signed; combinational.
// No handshake: the caller registers dout/clip.
module clarke_rndsat #(
  parameter int IN_W  = 45,
  parameter int OUT_W = 32,
  parameter int SHIFT = 10
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);
  localparam logic signed [IN_W:0] HALF = {{(IN_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] biased;
  logic signed [IN_W:0] shifted;

  // One guard bit keeps the rounding bias from wrapping the most positive input.
  assign biased  = {din[IN_W-1], din} + HALF;
  assign shifted = biased >>> SHIFT;

  always_comb begin
    dout = shifted[OUT_W-1:0];
    clip = 1'b0;
    if (shifted > MAXV) begin
      dout = MAXV[OUT_W-1:0];
      clip = 1'b1;
    end else if (shifted < MINV) begin
      dout = MINV[OUT_W-1:0];
      clip = 1'b1;
    end
  end
endmodule

// File: rtl/clarke_pipe.sv
// Pipelined Clarke abc->alpha/beta transform, 3-cycle latency, 1 sample/cycle.
// Global stall: every stage advances only when in_ready = !out_valid || out_ready.
module clarke_pipe import clarke_pkg::*; #(
  parameter int D_WIDTH   = 32,
  parameter int Q_BITS    = 10,
  parameter int N_CH      = 4,
  parameter int SAT_CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  clarke_pipe_if.slave io
);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SUM_W  = D_WIDTH + 2;
  localparam int PROD_W = D_WIDTH + Q_BITS + 3;

  localparam logic signed [PROD_W-1:0] K1 = PROD_W'(clarke_coef(Q_BITS, 1'b1));
  localparam logic signed [PROD_W-1:0] K3 = PROD_W'(clarke_coef(Q_BITS, 1'b0));
  localparam logic [SAT_CNT_W-1:0]     CNT_MAX = '1;

  logic                     rdy_q;
  logic                     adv;
  clarke_mode_t             in_mode;
  stage_t                   s1, s2;
  logic signed [SUM_W-1:0]  a_x, b_x, c_x;
  logic signed [SUM_W-1:0]  sum_al, sum_be, s1_al, s1_be;
  logic signed [PROD_W-1:0] prod_al, prod_be, s2_al, s2_be;
  logic signed [D_WIDTH-1:0] rs_al, rs_be;
  logic                     clip_al, clip_be;
  logic [CH_W_MAX-1:0]      ch_unused;

  // rdy_q keeps in_ready low through reset and for the first edge after release.
  assign adv         = rdy_q & (~io.out_valid | io.out_ready);
  assign io.in_ready = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= 1'b1;
  end

  assign in_mode = clarke_mode_t'(io.in_mode);
  assign a_x     = SUM_W'(io.in_a);
  assign b_x     = SUM_W'(io.in_b);
  assign c_x     = SUM_W'(io.in_c);

  always_comb begin
    sum_al = a_x;
    sum_be = a_x + (b_x <<< 1);
    if (in_mode == CLK_3PH) begin
      sum_al = (a_x <<< 1) - b_x - c_x;
      sum_be = b_x - c_x;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= '0;
      s1_al <= '0;
      s1_be <= '0;
    end else if (adv) begin
      s1.valid <= io.in_valid;
      s1.mode  <= in_mode;
      s1.ch    <= CH_W_MAX'(io.in_ch);
      s1_al    <= sum_al;
      s1_be    <= sum_be;
    end
  end

  // Two-phase alpha is pre-scaled by 2^Q so the shared round stage returns it unchanged.
  always_comb begin
    prod_be = PROD_W'(s1_be) * K1;
    prod_al = PROD_W'(s1_al) <<< Q_BITS;
    if (s1.mode == CLK_3PH) prod_al = PROD_W'(s1_al) * K3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2    <= '0;
      s2_al <= '0;
      s2_be <= '0;
    end else if (adv) begin
      s2    <= s1;
      s2_al <= prod_al;
      s2_be <= prod_be;
    end
  end

  clarke_rndsat #(.IN_W(PROD_W), .OUT_W(D_WIDTH), .SHIFT(Q_BITS)) u_rs_alpha (
    .din  (s2_al),
    .dout (rs_al),
    .clip (clip_al)
  );

  clarke_rndsat #(.IN_W(PROD_W), .OUT_W(D_WIDTH), .SHIFT(Q_BITS)) u_rs_beta (
    .din  (s2_be),
    .dout (rs_be),
    .clip (clip_be)
  );

  // Tag bits above CH_W are always zero.
  assign ch_unused = s2.ch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io.out_valid <= 1'b0;
      io.out_ch    <= '0;
      io.out_alpha <= '0;
      io.out_beta  <= '0;
      io.out_sat   <= 1'b0;
    end else if (adv) begin
      io.out_valid <= s2.valid;
      io.out_ch    <= s2.ch[CH_W-1:0];
      io.out_alpha <= rs_al;
      io.out_beta  <= rs_be;
      io.out_sat   <= s2.valid & (clip_be | ((s2.mode == CLK_3PH) & clip_al));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io.sat_cnt <= '0;
    end else if (io.clr_sat) begin
      io.sat_cnt <= '0;
    end else if (io.out_valid & io.out_ready & io.out_sat & (io.sat_cnt != CNT_MAX)) begin
      io.sat_cnt <= io.sat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_clarke_pipe.sv
// Directed bench for clarke_pipe with an arithmetic reference model and scoreboard.
// One compare process checks every transferred output, hold stability and sat_cnt.
module tb_clarke_pipe;
  localparam int DW  = 16;
  localparam int QB  = 10;
  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int SW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clarke_pipe_if #(.D_WIDTH(DW), .CH_W(CW), .SAT_CNT_W(SW)) io ();

  clarke_pipe #(.D_WIDTH(DW), .Q_BITS(QB), .N_CH(NCH), .SAT_CNT_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct {
    logic [CW-1:0] ch;
    longint        al;
    longint        be;
    bit            sat;
  } exp_t;

  exp_t   expq[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_out   = 0;
  longint mcnt    = 0;
  bit     rand_en = 1'b0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Round half up: floor((x + 2^(Q-1)) / 2^Q) with true floor division.
  function automatic longint rnd_q(input longint x);
    longint y;
    longint q;
    y = x + 512;
    q = y / 1024;
    if ((y % 1024 != 0) && (y < 0)) q = q - 1;
    return q;
  endfunction

  function automatic exp_t model(input bit mode, input logic [CW-1:0] ch,
                                 input longint a, input longint b, input longint c);
    exp_t e;
    e.ch  = ch;
    e.sat = 1'b0;
    if (!mode) begin
      e.al = a;
      e.be = rnd_q((a + 2 * b) * 591);
    end else begin
      e.al = rnd_q((2 * a - b - c) * 341);
      e.be = rnd_q((b - c) * 591);
    end
    if (e.al > 32767)  begin e.al = 32767;  e.sat = 1'b1; end
    if (e.al < -32768) begin e.al = -32768; e.sat = 1'b1; end
    if (e.be > 32767)  begin e.be = 32767;  e.sat = 1'b1; end
    if (e.be < -32768) begin e.be = -32768; e.sat = 1'b1; end
    return e;
  endfunction

  task automatic send(input bit mode, input logic [CW-1:0] ch,
                      input longint a, input longint b, input longint c);
    int waited;
    waited      = 0;
    io.in_valid = 1'b1;
    io.in_mode  = mode;
    io.in_ch    = ch;
    io.in_a     = DW'(a);
    io.in_b     = DW'(b);
    io.in_c     = DW'(c);
    @(negedge clk);
    while (!io.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!io.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", waited);
    end else begin
      expq.push_back(model(mode, ch, a, b, c));
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(io.out_valid && io.out_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, io.out_valid && io.out_ready, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", expq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    io.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      io.out_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic                 hold_v;
  logic [CW-1:0]        hold_ch;
  logic signed [DW-1:0] hold_al, hold_be;
  logic                 hold_sat;
  bit                   stalled = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    bit   xfer;
    bit   esat;
    if (rst) begin
      mcnt    = 0;
      stalled = 1'b0;
    end else begin
      chk("sat_cnt", io.sat_cnt, mcnt);
      if (stalled) begin
        chk("hold_valid", io.out_valid, hold_v);
        chk("hold_alpha", io.out_alpha, hold_al);
        chk("hold_beta",  io.out_beta,  hold_be);
        chk("hold_ch",    io.out_ch,    hold_ch);
        chk("hold_sat",   io.out_sat,   hold_sat);
      end
      xfer = io.out_valid && io.out_ready;
      esat = 1'b0;
      if (xfer) begin
        n_out++;
        if (expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: alpha=%0d beta=%0d, expected no output", io.out_alpha, io.out_beta);
        end else begin
          e    = expq.pop_front();
          esat = e.sat;
          chk("out_alpha", io.out_alpha, e.al);
          chk("out_beta",  io.out_beta,  e.be);
          chk("out_ch",    io.out_ch,    e.ch);
          chk("out_sat",   io.out_sat,   e.sat);
        end
      end
      if (io.clr_sat) mcnt = 0;
      else if (xfer && esat && mcnt < 65535) mcnt++;
      stalled  = io.out_valid && !io.out_ready;
      hold_v   = io.out_valid;
      hold_al  = io.out_alpha;
      hold_be  = io.out_beta;
      hold_ch  = io.out_ch;
      hold_sat = io.out_sat;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    io.in_valid = 1'b0;
    io.in_mode  = 1'b0;
    io.in_ch    = '0;
    io.in_a     = '0;
    io.in_b     = '0;
    io.in_c     = '0;
    io.clr_sat  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_in_ready",  io.in_ready,  0);
    chk("rst_sat_cnt",   io.sat_cnt,   0);
    chk("rst_alpha",     io.out_alpha, 0);
    chk("rst_beta",      io.out_beta,  0);
    chk("rst_ch",        io.out_ch,    0);
    chk("rst_sat",       io.out_sat,   0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_release", io.in_ready, 0);
    @(negedge clk);
    chk("in_ready_after", io.in_ready, 1);
    @(posedge clk);
    #1;

    // Two-phase latency and literal results.
    send(1'b0, 2'd2, 1024, 0, 0);
    @(negedge clk);
    chk("lat_cycle1", io.out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2", io.out_valid, 0);
    @(negedge clk);
    chk("lat_cycle3", io.out_valid, 1);
    chk("m0_alpha", io.out_alpha, 1024);
    chk("m0_beta",  io.out_beta,  591);
    chk("m0_ch",    io.out_ch,    2);
    chk("m0_sat",   io.out_sat,   0);
    @(posedge clk);
    #1;

    // Three-phase literals, back to back.
    send(1'b1, 2'd1, 1024, -512, -512);
    send(1'b1, 2'd3, 0, 1024, -1024);
    wait_out("m1a_seen");
    chk("m1a_alpha", io.out_alpha, 1023);
    chk("m1a_beta",  io.out_beta,  0);
    wait_out("m1b_seen");
    chk("m1b_alpha", io.out_alpha, 0);
    chk("m1b_beta",  io.out_beta,  1182);
    @(posedge clk);
    #1;

    // Negative full-scale two-phase sample saturates beta.
    send(1'b0, 2'd1, -32768, -32768, 0);
    wait_out("sat_seen");
    chk("sat_alpha",      io.out_alpha, -32768);
    chk("sat_beta",       io.out_beta,  -32768);
    chk("sat_flag",       io.out_sat,   1);
    chk("sat_cnt_before", io.sat_cnt,   0);
    @(negedge clk);
    chk("sat_cnt_after",  io.sat_cnt,   1);
    @(posedge clk);
    #1;

    // Mixed-mode stream under random backpressure.
    rand_en = 1'b1;
    send(1'b0, 2'd0, 100, 200, 0);
    send(1'b1, 2'd1, -300, 400, -100);
    send(1'b1, 2'd2, 20000, -20000, 0);
    send(1'b0, 2'd3, -5000, 7000, 0);
    send(1'b1, 2'd0, 32767, -32768, -32768);
    send(1'b0, 2'd1, 32767, 32767, 0);
    send(1'b1, 2'd2, -1, 1, 0);
    send(1'b0, 2'd3, 7, -3, 0);
    rand_en = 1'b0;
    drain();

    // Drive the counter into its ceiling.
    for (int i = 0; i < 65536; i++) send(1'b0, 2'd0, -32768, -32768, 0);
    drain();
    chk("sat_cnt_max", io.sat_cnt, 65535);

    // Clear coinciding with a clipped transfer.
    send(1'b0, 2'd0, -32768, -32768, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    io.clr_sat = 1'b1;
    @(negedge clk);
    chk("clr_xfer_sat", io.out_valid && io.out_ready && io.out_sat, 1);
    @(posedge clk);
    #1;
    io.clr_sat = 1'b0;
    chk("sat_cnt_clr", io.sat_cnt, 0);

    // Reset with samples in flight.
    send(1'b1, 2'd1, 100, -50, -50);
    send(1'b0, 2'd2, 10, 20, 0);
    send(1'b1, 2'd3, 0, 300, -300);
    rst = 1'b1;
    expq.delete();
    #1;
    chk("rst_flush_valid", io.out_valid, 0);
    chk("rst_flush_ready", io.in_ready,  0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    base = n_out;
    send(1'b0, 2'd1, 111, 222, 0);
    send(1'b1, 2'd2, -100, 50, 50);
    drain();
    chk("post_rst_count", n_out - base, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
